// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq: iterative radix-4 Booth multiplier, one digit per clock,
// valid/ready handshakes on operand and product sides.
module booth_r4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     X_i,
  input  logic [WIDTH-1:0]     Y_i,
  input  logic                 signed_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   Output_o
);
  localparam int D  = WIDTH / 2 + 1;
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(D + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d, xs_q, xs_d, mag, pp;
  logic [WIDTH+2:0]   ys_q, ys_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  // xs holds the multiplicand pre-shifted by 2i; ys holds {y, y[-1]} shifted so bits [2:0] are the current digit
  always_comb begin
    mag     = (ys_q[1] ^ ys_q[0]) ? xs_q : ((ys_q[2] != ys_q[1]) ? (xs_q << 1) : '0);
    pp      = ys_q[2] ? -mag : mag;
    state_d = state_q;
    acc_d   = acc_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (valid_i) begin
        state_d = CALC;
        xs_d    = {{(AW-WIDTH){signed_i & X_i[WIDTH-1]}}, X_i};
        ys_d    = {{2{signed_i & Y_i[WIDTH-1]}}, Y_i, 1'b0};
        acc_d   = '0;
        cnt_d   = '0;
      end
      CALC: if (cnt_q == CW'(D)) begin
        state_d = DONE;
        out_d   = acc_q[2*WIDTH-1:0];
      end else begin
        acc_d = acc_q + pp;
        xs_d  = xs_q << 2;
        ys_d  = ys_q >> 2;
        cnt_d = cnt_q + 1'b1;
      end
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign Output_o = out_q;
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb_booth_r4_mult_seq: scoreboarded random and directed checks of 8- and 16-bit instances
module tb_booth_r4_mult_seq;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] jx, jy;
  logic js;
  always @(negedge clk) begin
    jx = 16'($urandom);
    jy = 16'($urandom);
    js = 1'($urandom);
  end

  logic v8, s8, r8, rdy8, vo8;
  logic [7:0] x8, y8;
  logic [15:0] o8;
  logic v16, s16, r16, rdy16, vo16;
  logic [15:0] x16, y16;
  logic [31:0] o16;

  booth_r4_mult_seq #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .ready_o(rdy8),
    .X_i(v8 ? x8 : jx[7:0]), .Y_i(v8 ? y8 : jy[7:0]), .signed_i(v8 ? s8 : js),
    .valid_o(vo8), .ready_i(r8), .Output_o(o8));

  booth_r4_mult_seq #(.WIDTH(16)) u16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .ready_o(rdy16),
    .X_i(v16 ? x16 : jx), .Y_i(v16 ? y16 : jy), .signed_i(v16 ? s16 : js),
    .valid_o(vo16), .ready_i(r16), .Output_o(o16));

  function automatic logic [63:0] model(logic [15:0] x, logic [15:0] y, logic s, int w);
    longint a = longint'(x), b = longint'(y);
    if (s && x[w-1]) a -= longint'(1) << w;
    if (s && y[w-1]) b -= longint'(1) << w;
    return 64'(a * b) & ((64'd1 << (2 * w)) - 1);
  endfunction

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endfunction

  logic [63:0] q8[$], q16[$];
  bit inf8 = 0, inf16 = 0, pv8 = 0, pr8 = 0, pv16 = 0, pr16 = 0;
  longint acc8 = 0, acc16 = 0;
  logic [15:0] po8;
  logic [31:0] po16;

  always @(negedge clk) if (!rst) begin
    chk("ready8", 64'(rdy8), 64'(!inf8));
    if (vo8 && !pv8) chk("lat8", 64'(cyc - acc8), 6);
    if (vo8 && pv8 && !pr8) chk("hold8", 64'(o8), 64'(po8));
    if (vo8 && r8) begin
      if (q8.size() == 0) chk("extra8", 1, 0);
      else chk("prod8", 64'(o8), q8.pop_front());
      inf8 = 0;
    end
    pv8 = vo8; pr8 = r8; po8 = o8;
  end

  always @(negedge clk) if (!rst) begin
    chk("ready16", 64'(rdy16), 64'(!inf16));
    if (vo16 && !pv16) chk("lat16", 64'(cyc - acc16), 10);
    if (vo16 && pv16 && !pr16) chk("hold16", 64'(o16), 64'(po16));
    if (vo16 && r16) begin
      if (q16.size() == 0) chk("extra16", 1, 0);
      else chk("prod16", 64'(o16), q16.pop_front());
      inf16 = 0;
    end
    pv16 = vo16; pr16 = r16; po16 = o16;
  end

  task automatic issue8(logic [7:0] x, logic [7:0] y, logic s);
    int n = 0;
    while (!rdy8) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin chk("timeout8", 0, 1); return; end
    end
    v8 = 1; x8 = x; y8 = y; s8 = s;
    @(posedge clk);
    q8.push_back(model(16'(x), 16'(y), s, 8));
    acc8 = cyc + 1;
    inf8 = 1;
    #1 v8 = 0;
  endtask

  task automatic issue16(logic [15:0] x, logic [15:0] y, logic s);
    int n = 0;
    while (!rdy16) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin chk("timeout16", 0, 1); return; end
    end
    v16 = 1; x16 = x; y16 = y; s16 = s;
    @(posedge clk);
    q16.push_back(model(x, y, s, 16));
    acc16 = cyc + 1;
    inf16 = 1;
    #1 v16 = 0;
  endtask

  task automatic drain8();
    int n = 0;
    while (inf8) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin chk("drain8", 0, 1); inf8 = 0; q8.delete(); return; end
    end
  endtask

  task automatic drain16();
    int n = 0;
    while (inf16) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin chk("drain16", 0, 1); inf16 = 0; q16.delete(); return; end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    v8 = 0; x8 = 0; y8 = 0; s8 = 0; r8 = 1;
    v16 = 0; x16 = 0; y16 = 0; s16 = 0; r16 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready8", 64'(rdy8), 1);
    chk("rst_valid8", 64'(vo8), 0);
    chk("rst_out8", 64'(o8), 0);
    chk("rst_ready16", 64'(rdy16), 1);
    chk("rst_valid16", 64'(vo16), 0);
    chk("rst_out16", 64'(o16), 0);
    @(posedge clk); #1;
    issue8(8'hFF, 8'hFF, 0);
    drain8();
    issue8(8'h80, 8'h80, 1);
    issue8(8'h80, 8'h7F, 1);
    issue8(8'hFF, 8'h7F, 1);
    drain8();
    issue8(8'h80, 8'h02, 0);
    drain8();
    // backpressure: product must hold and DONE must ignore valid_i
    r8 = 0;
    issue8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int n = 0; !vo8; n++) begin
      if (n > 20) begin chk("bp_wait8", 0, 1); break; end
      @(posedge clk); #1;
    end
    repeat (4) begin
      v8 = 1; x8 = 8'($urandom); y8 = 8'($urandom); s8 = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("bp_valid8", 64'(vo8), 1);
    v8 = 0; r8 = 1;
    drain8();
    // reset during the third CALC cycle aborts the product
    issue8(8'h55, 8'h66, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; q8.delete(); inf8 = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_ready8", 64'(rdy8), 1);
    chk("abort_valid8", 64'(vo8), 0);
    chk("abort_out8", 64'(o8), 0);
    @(posedge clk); #1;
    issue8(8'd3, 8'd5, 0);
    drain8();
    repeat (1000) issue8(8'($urandom), 8'($urandom), 1'($urandom));
    drain8();
    issue16(16'hFFFF, 16'hFFFF, 0);
    drain16();
    issue16(16'h8000, 16'h8000, 1);
    drain16();
    repeat (3000) issue16(16'($urandom), 16'($urandom), 1'($urandom));
    drain16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
